bmc_acs_sched: RTL
==================

# bmc_acs_sched

Scheduler for the time-multiplexed BMC/ACS array of the Viterbi decoder. Accepts received 2-bit symbol pairs over a valid/ready stream and buffers them in a 2-entry FIFO. Each symbol is presented to the shared BMC units and then to the ACS group array for `N_GROUPS` consecutive cycles. At each frame boundary it hands off to traceback and stalls until traceback reports done. It sits between the demodulator/depuncturer output and the bmc/acs datapath.

## Interface
- `N_GROUPS`, 4: ACS groups sharing the array per symbol (power of 2, ≥2); `GW = clog2(N_GROUPS)`.
- `FRAME_LEN`, 64: symbols per frame (power of 2, ≥2); `SW = clog2(FRAME_LEN)`.
- `clk`  in  1  single clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream symbol valid.
- `in_ready`  out  1  FIFO can accept a symbol.
- `in_pair`  in  2  received pair {bit1, bit0}.
- `bmc_pair`  out  2  pair driven to all BMC units (`rx_pair`).
- `acs_en`  out  1  ACS group `acs_grp` updates this cycle.
- `acs_grp`  out  GW  ACS group index.
- `acs_first`  out  1  symbol is frame symbol 0 (ACS loads initial metrics).
- `sym_last`  out  1  last group of current symbol (path-metric bank swap, survivor write).
- `sym_idx`  out  SW  symbol index within the frame.
- `tb_start`  out  1  one-cycle pulse: frame complete, start traceback.
- `tb_done`  in  1  traceback finished (single-cycle pulse or level, sampled).
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- FIFO: 2 entries, registered count 0..2. Push on `in_valid & in_ready`; pop on the cycle where `acs_en & sym_last` is registered out. `in_ready = (count != 2)`, derived from the registered count only. No combinational path from pop; a full FIFO refuses a push even in a pop cycle. Push and pop in the same cycle keep the count unchanged.
- FSM states: IDLE, RUN, TB_WAIT.
  - IDLE → RUN when the FIFO is non-empty.
  - RUN: head entry drives `bmc_pair`. `acs_grp` counts 0..N_GROUPS-1 with `acs_en=1` every cycle. A symbol, once started, always completes all groups; there is no mid-symbol stall.
  - At `acs_grp = N_GROUPS-1`: `sym_last=1` and the FIFO pops.
    - If `sym_idx = FRAME_LEN-1`: `sym_idx` wraps to 0, `tb_start` pulses on the next cycle, and the FSM goes to TB_WAIT.
    - Otherwise `sym_idx` increments. The FSM stays in RUN if the FIFO still holds a symbol after the pop; if it is empty, it goes to IDLE.
  - TB_WAIT: `acs_en=0`; the FIFO keeps accepting up to 2 entries. When `tb_done=1` is sampled: go to RUN if FIFO non-empty, else IDLE.
- `acs_first = (sym_idx == 0)` whenever `acs_en = 1`, else 0.
- `tb_done` is ignored outside TB_WAIT.
- `bmc_pair` holds its last value when `acs_en = 0`.
- Reset (asynchronous, any time, including mid-symbol or in TB_WAIT): FIFO empties, state goes to IDLE, and every output goes to 0 except `in_ready = 1`. The partial frame is discarded and no `tb_start` is issued.

## Timing
- All outputs except `in_ready` are registered.
- Push at edge t → earliest `acs_en` with that pair at cycle t+1 (from IDLE).
- Symbol occupancy is exactly `N_GROUPS` cycles. Back-to-back symbols with the FIFO non-empty give continuous `acs_en` with no bubble.
- Last group of frame symbol at cycle c → `tb_start=1` at c+1 only, with `acs_en=0` from c+1.
- `tb_done` sampled at edge d → `acs_en` may resume at d+1.
- Sustained throughput: 1 symbol per `N_GROUPS` cycles. `in_ready` drops when the count reaches 2 and rises the cycle after a pop.

## Test plan
- **Reset:** assert `rst_n=0` mid-symbol (`acs_grp=2`) → all outputs 0 and `in_ready=1` at once (asynchronous). After release, the next pushed pair starts at `acs_grp=0`, `sym_idx=0`, `acs_first=1`.
- **Single symbol:** push `in_pair=2'b10` from IDLE (defaults) → `acs_en` for 4 cycles with `acs_grp` 0,1,2,3, `bmc_pair=2'b10`, `sym_last` only on grp 3. FSM returns to IDLE, `busy=0`, `sym_idx=1`.
- **Streaming:** `in_valid` held high with pairs 00,01,10,11,… → continuous `acs_en` with no bubbles. `in_ready` toggles so the accepted rate is 1 per 4 cycles. Pairs emerge in order and none are lost or duplicated.
- **Frame boundary:** stream 64 symbols → `tb_start` exactly once, one cycle after the `sym_last` of `sym_idx=63`. `acs_en` stays 0 while 2 more symbols are accepted, then `in_ready=0`. Pulse `tb_done` → next cycle resumes with `sym_idx=0` and `acs_first=1`.
- **Spurious `tb_done`:** pulse `tb_done` while in RUN and in IDLE → no state or output change.
- **FIFO full:** FIFO full and `in_valid=1` during the pop cycle → push refused that cycle and accepted the cycle after. Count never exceeds 2.

Source files
------------

// File: rtl/bmc_acs_sched.sv
// Symbol scheduler for the time-multiplexed BMC/ACS array: buffers received pairs in a
// 2-entry FIFO, sweeps every ACS group once per symbol and hands each frame to traceback.
module bmc_acs_sched #(
  parameter  int N_GROUPS  = 4,
  parameter  int FRAME_LEN = 64,
  localparam int GW        = $clog2(N_GROUPS),
  localparam int SW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_pair,
  output logic [1:0]    bmc_pair,
  output logic          acs_en,
  output logic [GW-1:0] acs_grp,
  output logic          acs_first,
  output logic          sym_last,
  output logic [SW-1:0] sym_idx,
  output logic          tb_start,
  input  logic          tb_done,
  output logic          busy
);

  localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUPS - 1);
  localparam logic [SW-1:0] LAST_SYM = SW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TB_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic          push;
  logic          pop;
  logic [1:0]    head;
  logic [1:0]    head_after_pop;
  logic [GW-1:0] grp_inc;

  // Readiness depends on the registered count only, so a pop never opens a slot early.
  assign in_ready = (count != 2'd2);

  always_comb begin
    // NOTE: every variable gets a value on every path here; a missing default would infer a latch.
    push           = in_valid & in_ready;
    pop            = acs_en & sym_last;
    count_nxt      = count;
    if (push && !pop) begin
      count_nxt = count + 2'd1;
    end else if (pop && !push) begin
      count_nxt = count - 2'd1;
    end
    head           = mem[rd_ptr];
    // With one entry left the pair arriving on this edge becomes the next head.
    head_after_pop = (count == 2'd2) ? mem[~rd_ptr] : in_pair;
    grp_inc        = acs_grp + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: the storage array is not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pair;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bmc_pair  <= 2'b00;
      acs_en    <= 1'b0;
      acs_grp   <= '0;
      acs_first <= 1'b0;
      sym_last  <= 1'b0;
      sym_idx   <= '0;
      tb_start  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tb_start <= 1'b0;
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            state     <= RUN;
            acs_en    <= 1'b1;
            acs_grp   <= '0;
            sym_last  <= 1'b0;
            acs_first <= (sym_idx == '0);
            bmc_pair  <= head;
            busy      <= 1'b1;
          end else begin
            busy <= (count_nxt != 2'd0);
          end
        end

        RUN: begin
          if (!sym_last) begin
            acs_grp  <= grp_inc;
            sym_last <= (grp_inc == LAST_GRP);
            busy     <= 1'b1;
          end else begin
            acs_grp  <= '0;
            sym_last <= 1'b0;
            if (sym_idx == LAST_SYM) begin
              sym_idx   <= '0;
              tb_start  <= 1'b1;
              state     <= TB_WAIT;
              acs_en    <= 1'b0;
              acs_first <= 1'b0;
              busy      <= 1'b1;
            end else begin
              sym_idx   <= sym_idx + 1'b1;
              acs_first <= 1'b0;
              if (count_nxt != 2'd0) begin
                // Next symbol starts straight away: no bubble between symbols.
                acs_en   <= 1'b1;
                bmc_pair <= head_after_pop;
                busy     <= 1'b1;
              end else begin
                state  <= IDLE;
                acs_en <= 1'b0;
                busy   <= 1'b0;
              end
            end
          end
        end

        TB_WAIT: begin
          if (tb_done) begin
            if (count != 2'd0) begin
              state     <= RUN;
              acs_en    <= 1'b1;
              acs_grp   <= '0;
              sym_last  <= 1'b0;
              acs_first <= (sym_idx == '0);
              bmc_pair  <= head;
              busy      <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= (count_nxt != 2'd0);
            end
          end else begin
            busy <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
